// File: rtl/neurram_spi_arbiter.sv
// Round-robin arbiter sharing one neurram_spi_control engine between the host
// path (req 0) and the inference sequencer (req 1).
module neurram_spi_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned RUN_TIMEOUT = 1 << 22,
  parameter int unsigned CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [35:0] req_desc,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        done_err,
  output logic        err_timeout,
  input  logic        err_clear,
  output logic        busy,
  output logic        spi_trigger,
  output logic [1:0]  spi_config,
  output logic [3:0]  shift_multiplier,
  output logic [3:0]  pipe_in_steps,
  output logic [3:0]  pipe_out_steps,
  output logic [3:0]  extra_shift_cycles,
  input  logic        spi_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_ACK,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       last_served;  // one-hot; 0 until the first transfer completes
  logic             err_q;
  logic [1:0]       win;
  logic [17:0]      sel_desc;
  logic             arb_go;
  logic             zero_len;
  logic             ack_to;
  logic             run_to;

  // Arbitration: a sole requester wins; on a tie the one not served last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_served[0] ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

  assign sel_desc = win[1] ? req_desc[35:18] : req_desc[17:0];
  assign arb_go   = (state == S_IDLE) && spi_idle && (req != 2'b00);
  assign zero_len = ({1'b0, sel_desc[15:12]} + {1'b0, sel_desc[3:0]}) == 5'd0;
  assign cnt_inc  = cnt + 1'b1;
  assign ack_to   = (state == S_ACK) && spi_idle && (cnt_inc == ACK_LIM);
  assign run_to   = (state == S_RUN) && !spi_idle && (cnt_inc == RUN_LIM);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (arb_go) state_nxt = zero_len ? S_DONE : S_TRIG;
      S_TRIG: state_nxt = S_ACK;
      S_ACK: begin
        if (!spi_idle)   state_nxt = S_RUN;
        else if (ack_to) state_nxt = S_DONE;
      end
      S_RUN: begin
        if (spi_idle)    state_nxt = S_DONE;
        else if (run_to) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: owner, descriptor latch, timeout counter, error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant              <= 2'b00;
      last_served        <= 2'b00;
      cnt                <= '0;
      err_q              <= 1'b0;
      err_timeout        <= 1'b0;
      spi_config         <= 2'b00;
      shift_multiplier   <= 4'd0;
      pipe_in_steps      <= 4'd0;
      pipe_out_steps     <= 4'd0;
      extra_shift_cycles <= 4'd0;
    end else begin
      if (arb_go) begin
        grant              <= win;
        cnt                <= '0;
        err_q              <= zero_len;
        spi_config         <= sel_desc[17:16];
        shift_multiplier   <= sel_desc[15:12];
        pipe_in_steps      <= sel_desc[11:8];
        pipe_out_steps     <= sel_desc[7:4];
        extra_shift_cycles <= sel_desc[3:0];
      end

      if (state == S_ACK)      cnt <= spi_idle ? cnt_inc : '0;
      else if (state == S_RUN) cnt <= cnt_inc;

      if (ack_to || run_to) err_q <= 1'b1;

      if (state == S_DONE) begin
        grant       <= 2'b00;
        last_served <= grant;
      end

      // A timeout in the same cycle as err_clear still sets the flag.
      if (ack_to || run_to) err_timeout <= 1'b1;
      else if (err_clear)   err_timeout <= 1'b0;
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy        = (state != S_IDLE);
    spi_trigger = (state == S_TRIG);
    done        = (state == S_DONE) ? grant : 2'b00;
    done_err    = (state == S_DONE) && err_q;
  end

endmodule
